// File: rtl/core_clk_rst_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : core_clk_rst_sequencer
// Description : Moore FSM that sequences the core clock-gate enable and the
//               core reset release (settle -> hold -> ready -> run -> drain).
// Revision    : 1.0 - initial release
// ============================================================================
module core_clk_rst_sequencer #(
    parameter int CLK_SETTLE_CYCLES = 4,
    parameter int RST_HOLD_CYCLES   = 8,
    parameter int CNT_W             = 8
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       clk_core_en_i,
    input  logic       rst_n_core_i,
    output logic       clk_gate_en_o,
    output logic       rst_n_core_o,
    output logic       busy_o,
    output logic [2:0] state_o
);

    if ((CLK_SETTLE_CYCLES < 1) || (CLK_SETTLE_CYCLES >= (2 ** CNT_W))) begin : g_settle_range_err
        $error("CLK_SETTLE_CYCLES must be in [1, 2**CNT_W - 1]");
    end

    if ((RST_HOLD_CYCLES < 1) || (RST_HOLD_CYCLES >= (2 ** CNT_W))) begin : g_hold_range_err
        $error("RST_HOLD_CYCLES must be in [1, 2**CNT_W - 1]");
    end

    typedef enum logic [2:0] {
        ST_OFF    = 3'd0,
        ST_SETTLE = 3'd1,
        ST_HOLD   = 3'd2,
        ST_READY  = 3'd3,
        ST_RUN    = 3'd4,
        ST_DRAIN  = 3'd5
    } state_t;

    localparam logic [CNT_W-1:0] c_SETTLE_LOAD = CNT_W'(CLK_SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] c_HOLD_LOAD   = CNT_W'(RST_HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] c_CNT_ONE     = CNT_W'(1);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [CNT_W-1:0] w_cnt_dec;
    logic             w_cnt_zero;

    assign w_cnt_dec  = r_cnt - c_CNT_ONE;
    assign w_cnt_zero = (r_cnt == '0);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= ST_OFF;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Clock-disable is tested first everywhere so it outranks a reset request.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            ST_OFF: begin
                if (clk_core_en_i) begin
                    w_state_nxt = ST_SETTLE;
                    w_cnt_nxt   = c_SETTLE_LOAD;
                end
            end
            ST_SETTLE: begin
                if (!clk_core_en_i) begin
                    w_state_nxt = ST_OFF;
                end else if (w_cnt_zero) begin
                    w_state_nxt = ST_HOLD;
                    w_cnt_nxt   = c_HOLD_LOAD;
                end else begin
                    w_cnt_nxt   = w_cnt_dec;
                end
            end
            ST_HOLD: begin
                if (!clk_core_en_i) begin
                    w_state_nxt = ST_OFF;
                end else if (w_cnt_zero) begin
                    w_state_nxt = ST_READY;
                end else begin
                    w_cnt_nxt   = w_cnt_dec;
                end
            end
            ST_READY: begin
                if (!clk_core_en_i) begin
                    w_state_nxt = ST_OFF;
                end else if (rst_n_core_i) begin
                    w_state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                if (!clk_core_en_i) begin
                    w_state_nxt = ST_DRAIN;
                    w_cnt_nxt   = c_HOLD_LOAD;
                end else if (!rst_n_core_i) begin
                    w_state_nxt = ST_HOLD;
                    w_cnt_nxt   = c_HOLD_LOAD;
                end
            end
            ST_DRAIN: begin
                if (w_cnt_zero) begin
                    w_state_nxt = ST_OFF;
                end else begin
                    w_cnt_nxt   = w_cnt_dec;
                end
            end
            default: begin
                w_state_nxt = ST_OFF;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    always_comb begin
        clk_gate_en_o = 1'b0;
        rst_n_core_o  = 1'b0;
        busy_o        = 1'b0;
        case (r_state)
            ST_SETTLE: begin
                clk_gate_en_o = 1'b1;
                busy_o        = 1'b1;
            end
            ST_HOLD: begin
                clk_gate_en_o = 1'b1;
                busy_o        = 1'b1;
            end
            ST_READY: begin
                clk_gate_en_o = 1'b1;
            end
            ST_RUN: begin
                clk_gate_en_o = 1'b1;
                rst_n_core_o  = 1'b1;
            end
            ST_DRAIN: begin
                clk_gate_en_o = 1'b1;
                busy_o        = 1'b1;
            end
            default: begin
                clk_gate_en_o = 1'b0;
            end
        endcase
    end

    assign state_o = r_state;

endmodule
`default_nettype wire

// File: tb/tb_core_clk_rst_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_core_clk_rst_sequencer
// Description : Self-checking bench: deadline-based phase model plus directed
//               and randomized stimulus for core_clk_rst_sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_core_clk_rst_sequencer;

    localparam int S = 4;
    localparam int H = 8;

    logic       clk_i = 1'b0;
    logic       rst_ni = 1'b0;
    logic       clk_core_en_i = 1'b0;
    logic       rst_n_core_i = 1'b0;
    logic       clk_gate_en_o;
    logic       rst_n_core_o;
    logic       busy_o;
    logic [2:0] state_o;

    int checks = 0;
    int errors = 0;

    // Phase model: 0 off, 1 settle, 2 hold, 3 ready, 4 run, 5 drain.
    // Timed phases end at an absolute edge number rather than via a counter.
    int m_phase = 0;
    int m_end   = 0;
    int cyc     = 0;

    core_clk_rst_sequencer #(
        .CLK_SETTLE_CYCLES(S),
        .RST_HOLD_CYCLES  (H),
        .CNT_W            (8)
    ) dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .clk_core_en_i(clk_core_en_i),
        .rst_n_core_i (rst_n_core_i),
        .clk_gate_en_o(clk_gate_en_o),
        .rst_n_core_o (rst_n_core_o),
        .busy_o       (busy_o),
        .state_o      (state_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_edge(input logic en, input logic rel);
        cyc++;
        case (m_phase)
            0: if (en) begin m_phase = 1; m_end = cyc + S; end
            1: if (!en) m_phase = 0;
               else if (cyc == m_end) begin m_phase = 2; m_end = cyc + H; end
            2: if (!en) m_phase = 0;
               else if (cyc == m_end) m_phase = 3;
            3: if (!en) m_phase = 0;
               else if (rel) m_phase = 4;
            4: if (!en) begin m_phase = 5; m_end = cyc + H; end
               else if (!rel) begin m_phase = 2; m_end = cyc + H; end
            5: if (cyc == m_end) m_phase = 0;
            default: m_phase = 0;
        endcase
    endtask

    task automatic tick(input logic en, input logic rel);
        clk_core_en_i = en;
        rst_n_core_i  = rel;
        @(posedge clk_i);
        if (rst_ni) model_edge(en, rel);
        else m_phase = 0;
        #1;
    endtask

    always @(negedge clk_i) begin
        check("state_o", int'(state_o), m_phase);
        check("clk_gate_en_o", int'(clk_gate_en_o), int'(m_phase != 0));
        check("rst_n_core_o", int'(rst_n_core_o), int'(m_phase == 4));
        check("busy_o", int'(busy_o), int'(m_phase == 1 || m_phase == 2 || m_phase == 5));
        if (rst_n_core_o && !clk_gate_en_o) check("rst_without_clk", 1, 0);
    end

    initial begin
        int cnt;

        // Reset held with both requests high.
        tick(1'b1, 1'b1);
        tick(1'b1, 1'b1);
        check("rst_gate", int'(clk_gate_en_o), 0);
        check("rst_rstn", int'(rst_n_core_o), 0);
        check("rst_busy", int'(busy_o), 0);
        check("rst_state", int'(state_o), 0);
        clk_core_en_i = 1'b0;
        rst_ni = 1'b1;
        tick(1'b0, 1'b1);

        // Power-up: E0 is the first edge sampling enable.
        tick(1'b1, 1'b1);
        check("pu_gate_E0", int'(clk_gate_en_o), 1);
        check("pu_state_E0", int'(state_o), 1);
        for (int k = 1; k <= 13; k++) begin
            tick(1'b1, 1'b1);
            if (k == 3)  check("pu_state_E3", int'(state_o), 1);
            if (k == 4)  check("pu_state_E4", int'(state_o), 2);
            if (k == 11) check("pu_state_E11", int'(state_o), 2);
            if (k == 12) check("pu_state_E12", int'(state_o), 3);
            if (k == 12) check("pu_rstn_E12", int'(rst_n_core_o), 0);
            if (k == 13) check("pu_state_E13", int'(state_o), 4);
            if (k == 13) check("pu_rstn_E13", int'(rst_n_core_o), 1);
        end

        // Soft reset pulse.
        tick(1'b1, 1'b0);
        cnt = (rst_n_core_o == 1'b0) ? 1 : 0;
        for (int k = 0; k < 12; k++) begin
            tick(1'b1, 1'b1);
            if (!rst_n_core_o) cnt++;
            if (!clk_gate_en_o) check("soft_gate", 0, 1);
        end
        check("soft_rst_len", cnt, 9);

        // Clock disable from RUN.
        tick(1'b0, 1'b1);
        check("dis_rstn", int'(rst_n_core_o), 0);
        check("dis_busy", int'(busy_o), 1);
        cnt = clk_gate_en_o ? 1 : 0;
        for (int k = 0; k < 12; k++) begin
            tick(1'b0, 1'b1);
            if (clk_gate_en_o) cnt++;
        end
        check("drain_len", cnt, 8);
        check("dis_state_end", int'(state_o), 0);

        // Abort in HOLD with the counter at 3.
        tick(1'b1, 1'b1);
        for (int k = 1; k <= 8; k++) tick(1'b1, 1'b1);
        check("abort_pre_state", int'(state_o), 2);
        tick(1'b0, 1'b1);
        check("abort_state", int'(state_o), 0);
        check("abort_gate", int'(clk_gate_en_o), 0);

        // Both inputs drop in RUN, enable returns during DRAIN.
        for (int k = 0; k < 15; k++) tick(1'b1, 1'b1);
        check("sim_pre_run", int'(state_o), 4);
        tick(1'b0, 1'b0);
        check("sim_drain", int'(state_o), 5);
        for (int k = 1; k <= 7; k++) tick(1'b1, 1'b1);
        check("sim_drain_last", int'(state_o), 5);
        tick(1'b1, 1'b1);
        check("sim_off", int'(state_o), 0);
        tick(1'b1, 1'b1);
        check("sim_settle", int'(state_o), 1);

        // Asynchronous reset mid-sequence.
        tick(1'b1, 1'b1);
        #2 rst_ni = 1'b0;
        m_phase = 0;
        #1;
        check("async_state", int'(state_o), 0);
        check("async_gate", int'(clk_gate_en_o), 0);
        rst_ni = 1'b1;

        // Randomized traffic, biased towards enable and release.
        for (int k = 0; k < 4000; k++) begin
            tick(($urandom_range(0, 99) < 92) ? 1'b1 : 1'b0,
                 ($urandom_range(0, 99) < 88) ? 1'b1 : 1'b0);
            if ($urandom_range(0, 199) == 0) begin
                #2 rst_ni = 1'b0;
                m_phase = 0;
                #1;
                check("rand_async_state", int'(state_o), 0);
                rst_ni = 1'b1;
            end
        end

        @(negedge clk_i);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/core_clk_rst_sequencer.md
CORE_CLK_RST_SEQUENCER -- requirements
Module: core_clk_rst_sequencer

Interface
REQ-001 SHALL have parameter CLK_SETTLE_CYCLES, default 4: cycles the clock runs with reset held before the hold count starts.
REQ-002 SHALL have parameter RST_HOLD_CYCLES, default 8: minimum cycles reset stays asserted with the clock running.
REQ-003 SHALL have parameter CNT_W, default 8: width of the internal down-counter.
REQ-004 SHALL have port clk_i, input, 1 bit: clock.
REQ-005 SHALL have port rst_ni, input, 1 bit: reset, asynchronous, active-low.
REQ-006 SHALL have port clk_core_en_i, input, 1 bit: clock-enable request from the control register block.
REQ-007 SHALL have port rst_n_core_i, input, 1 bit: reset-release request from the control register block, 1 = release.
REQ-008 SHALL have port clk_gate_en_o, output, 1 bit: enable to the core clock gate.
REQ-009 SHALL have port rst_n_core_o, output, 1 bit: active-low reset to the core.
REQ-010 SHALL have port busy_o, output, 1 bit: a sequence is in progress.
REQ-011 SHALL have port state_o, output, 3 bits: current state encoding.

Function
REQ-012 SHALL implement a registered Moore FSM; every output decodes the current state only, with no input-to-output combinational path.
REQ-013 SHALL use the state encoding OFF=0, SETTLE=1, HOLD=2, READY=3, RUN=4, DRAIN=5; codes 6-7 SHALL go to OFF on the next edge.
REQ-014 SHALL drive clk_gate_en_o=1 in SETTLE, HOLD, READY, RUN and DRAIN; it SHALL be 0 in OFF.
REQ-015 SHALL drive rst_n_core_o=1 only in RUN.
REQ-016 SHALL drive busy_o=1 in SETTLE, HOLD and DRAIN.
REQ-017 OFF: when clk_core_en_i=1, SHALL go to SETTLE and load cnt=CLK_SETTLE_CYCLES-1.
REQ-018 SETTLE: if clk_core_en_i=0, SHALL go to OFF; else if cnt==0, SHALL go to HOLD and load cnt=RST_HOLD_CYCLES-1; else SHALL decrement cnt.
REQ-019 HOLD: if clk_core_en_i=0, SHALL go to OFF; else if cnt==0, SHALL go to READY; else SHALL decrement cnt.
REQ-020 READY: if clk_core_en_i=0, SHALL go to OFF; else if rst_n_core_i=1, SHALL go to RUN; else SHALL stay in READY.
REQ-021 RUN: if clk_core_en_i=0, SHALL go to DRAIN and load cnt=RST_HOLD_CYCLES-1; else if rst_n_core_i=0, SHALL go to HOLD and load cnt=RST_HOLD_CYCLES-1.
REQ-022 Simultaneous drop of both inputs in RUN SHALL take the DRAIN path (clock-disable has priority).
REQ-023 DRAIN: SHALL ignore both inputs; when cnt==0, SHALL go to OFF; else SHALL decrement cnt.
REQ-024 If clk_core_en_i re-asserts during DRAIN, it SHALL take effect only from OFF, on the first edge after DRAIN ends.
REQ-025 SETTLE SHALL last exactly CLK_SETTLE_CYCLES cycles; HOLD and DRAIN SHALL each last exactly RST_HOLD_CYCLES cycles when not aborted.
REQ-026 Latency from clk_gate_en_o rising to rst_n_core_o rising SHALL be CLK_SETTLE_CYCLES+RST_HOLD_CYCLES+1 cycles when rst_n_core_i is already 1.
REQ-027 The core SHALL never see rst_n_core_o=1 while clk_gate_en_o=0.
REQ-028 Both cycle parameters SHALL be >=1 and <2^CNT_W; an elaboration-time check SHALL reject any other value.

Reset
REQ-029 While rst_ni=0, SHALL hold state=OFF and cnt=0, giving clk_gate_en_o=0, rst_n_core_o=0, busy_o=0, state_o=0.
REQ-030 Asserting rst_ni mid-sequence SHALL force OFF immediately (asynchronous), with no drain phase.
REQ-031 After rst_ni deasserts, the first transition SHALL occur on the first clk_i edge with rst_ni=1.

Verification (defaults: settle 4, hold 8)
REQ-032 Reset: rst_ni=0 with both inputs=1 -> clk_gate_en_o=0, rst_n_core_o=0, busy_o=0, state_o=0.
REQ-033 Power-up: clk_core_en_i=1 and rst_n_core_i=1 sampled at edge E0 -> clk_gate_en_o=1 from E0, state_o=2 from E4, 3 from E12, 4 from E13, rst_n_core_o=1 from E13.
REQ-034 Soft reset: RUN, one-cycle rst_n_core_i=0 pulse -> rst_n_core_o=0 for 9 cycles (8 HOLD + 1 READY), clk_gate_en_o stays 1.
REQ-035 Clock disable: RUN, clk_core_en_i=0 -> rst_n_core_o=0 at the next edge, clk_gate_en_o stays 1 for 8 cycles then 0, busy_o=1 during DRAIN.
REQ-036 Abort: clk_core_en_i=0 while in HOLD at cnt=3 -> state_o=0 and clk_gate_en_o=0 at the next edge.
REQ-037 Simultaneous events: in RUN, both inputs drop at the same edge -> state_o=5; clk_core_en_i re-asserted during DRAIN -> OFF for one cycle, then SETTLE.
